uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_arb_if.sv | 30 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/uart_tx_arb.sv | 118 +++++++++++
 tb/tb_uart_tx_arb.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the two-port UART transmit arbiter.
// Holds the arbiter FSM state encoding and the default inter-frame gap length.
package uart_pkg;

  // Default number of idle cycles inserted between frames when the gap feature is built in.
  localparam int unsigned GapCyclesDefault = 16;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLaunch   = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StGap      = 3'd4
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of the requester handshakes and the transmitter launch port of uart_tx_arb.
//   req0_* / req1_*  : requester byte, valid, one-cycle ready pulse on acceptance
//   uart_tx_busy     : busy flag from the shared transmitter
//   uart_tx_en/data  : one-cycle launch strobe and the byte being launched
//   grant_id         : index of the most recently launched requester
//   arb_idle         : arbiter is waiting for work
// Modport master is the requester/transmitter side, slave is the arbiter.
interface uart_tx_arb_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       uart_tx_busy;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       grant_id;
  logic       arb_idle;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, uart_tx_busy,
    input  req0_ready, req1_ready, uart_tx_en, uart_tx_data, grant_id, arb_idle
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, uart_tx_busy,
    output req0_ready, req1_ready, uart_tx_en, uart_tx_data, grant_id, arb_idle
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin decision.
//   valid0_i, valid1_i : requests
//   last_grant_i       : index granted last time
//   grant_valid_o      : at least one request is present
//   grant_idx_o        : winning index; on contention the port that did not win last time
module rr_arb2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic grant_valid_o,
  output logic grant_idx_o
);

  always_comb begin
    grant_valid_o = valid0_i | valid1_i;
    if (valid0_i && valid1_i) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = valid1_i;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates two byte requesters onto one shared UART transmitter.
// A winner is picked round-robin in IDLE while the transmitter is free, its byte is
// registered, and a one-cycle launch strobe plus the winner's ready pulse are issued.
// The FSM then follows the transmitter busy flag through the frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_arb_if slave modport (requesters + transmitter port)
// Optional feature: define UART_TX_GAP_EN to insert GAP_CYCLES idle cycles after each frame.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = GapCyclesDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.slave  bus
);

  if (GAP_CYCLES == 0) begin : g_bad_gap
    $error("GAP_CYCLES must be at least 1");
  end

  arb_state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       grant_q, grant_d;
  logic       win_valid;
  logic       win_idx;

  rr_arb2 u_rr_arb2 (
    .valid0_i      (bus.req0_valid),
    .valid1_i      (bus.req1_valid),
    .last_grant_i  (grant_q),
    .grant_valid_o (win_valid),
    .grant_idx_o   (win_idx)
  );

`ifdef UART_TX_GAP_EN
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

  logic [15:0] gap_cnt_q, gap_cnt_d;

  // Counts cycles spent in GAP; cleared everywhere else so every gap starts from zero.
  always_comb begin
    gap_cnt_d = '0;
    if (state_q == StGap && gap_cnt_q != GapLast) begin
      gap_cnt_d = gap_cnt_q + 16'd1;
    end else if (state_q == StGap) begin
      gap_cnt_d = gap_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.uart_tx_busy && win_valid) begin
          state_d = StLaunch;
          data_d  = win_idx ? bus.req1_data : bus.req0_data;
          grant_d = win_idx;
        end
      end
      StLaunch: state_d = StWaitBusy;
      StWaitBusy: begin
        if (bus.uart_tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!bus.uart_tx_busy) begin
`ifdef UART_TX_GAP_EN
          state_d = StGap;
`else
          state_d = StIdle;
`endif
        end
      end
      StGap: begin
`ifdef UART_TX_GAP_EN
        if (gap_cnt_q == GapLast) state_d = StIdle;
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= 8'h00;
      grant_q <= 1'b1;  // so port 0 wins the first contention
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  // Outputs decode the registered state only, so reset clears them without waiting for a clock.
  always_comb begin
    bus.uart_tx_en   = (state_q == StLaunch);
    bus.req0_ready   = (state_q == StLaunch) && !grant_q;
    bus.req1_ready   = (state_q == StLaunch) && grant_q;
    bus.uart_tx_data = data_q;
    bus.grant_id     = grant_q;
    bus.arb_idle     = (state_q == StIdle);
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb. The transmitter and requesters are emulated by
// the tasks below; expected winners come from a round-robin model over the launch history.
module tb_uart_tx_arb;

  localparam int unsigned GapCycles = 16;
`ifdef UART_TX_GAP_EN
  localparam int GapExtra = GapCycles;
`else
  localparam int GapExtra = 0;
`endif
  // Inputs applied just after an edge; en becomes visible after the next edge (IDLE -> LAUNCH).
  localparam int LaunchLat   = 2;
  // After busy drops: WAIT_DONE -> (GAP) -> IDLE -> LAUNCH.
  localparam int RelaunchLat = 3 + GapExtra;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_grant;  // model: port launched most recently (1 out of reset)
  byte  unsigned last_byte;

  uart_tx_arb_if bus ();

  uart_tx_arb #(.GAP_CYCLES(GapCycles)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for a launch strobe, counting negedges from the call.
  task automatic wait_launch(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
      end
    end
  endtask

  // Transmitter model: busy rises after the launch cycle, holds, then drops.
  task automatic finish_frame(input int busy_len, output int en_seen);
    en_seen = 0;
    step();
    bus.uart_tx_busy = 1'b1;
    for (int i = 0; i < busy_len + 1; i++) begin
      @(negedge clk);
      if (bus.uart_tx_en === 1'b1) en_seen++;
      step();
    end
    bus.uart_tx_busy = 1'b0;
  endtask

  task automatic settle_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.arb_idle === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.uart_tx_en !== 1'b0) begin n_err++; $display("FAIL reset_en got %b want 0", bus.uart_tx_en); end
    n_cmp++; if (bus.uart_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.uart_tx_data); end
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got %b want 0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
    n_cmp++; if (bus.grant_id !== 1'b1) begin n_err++; $display("FAIL reset_grant got %b want 1", bus.grant_id); end
    n_cmp++; if (bus.arb_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got %b want 1", bus.arb_idle); end
    step();
    rst_n = 1'b1;
    last_grant = 1'b1;
    last_byte  = 8'h00;
  endtask

  task automatic test_single();
    int cyc, en_seen;
    bit ok;
    step();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    wait_launch(cyc, ok);
    n_cmp++; if (!ok || cyc != LaunchLat) begin n_err++; $display("FAIL single_latency got %0d want %0d", cyc, LaunchLat); end
    n_cmp++; if (bus.uart_tx_data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", bus.uart_tx_data); end
    n_cmp++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL single_ready got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL single_grant got %b want 0", bus.grant_id); end
    bus.req0_valid = 1'b0;
    last_grant = 1'b0;
    last_byte  = 8'hA5;
    @(negedge clk);
    n_cmp++; if (bus.uart_tx_en !== 1'b0 || bus.req0_ready !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_width got en=%b rdy=%b want 0 0", bus.uart_tx_en, bus.req0_ready);
    end
    finish_frame(3, en_seen);
    settle_idle(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_return_idle got 0 want 1"); end
  endtask

  task automatic test_contention();
    int cyc, en_seen;
    bit ok, exp_port;
    byte unsigned exp_data;
    step();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
    for (int n = 0; n < 6; n++) begin
      exp_port = ~last_grant;
      exp_data = exp_port ? 8'h22 : 8'h11;
      wait_launch(cyc, ok);
      n_cmp++; if (!ok || cyc != (n == 0 ? LaunchLat : RelaunchLat)) begin
        n_err++; $display("FAIL contention_latency[%0d] got %0d want %0d", n, cyc, (n == 0 ? LaunchLat : RelaunchLat));
      end
      n_cmp++; if (bus.uart_tx_data !== exp_data || bus.grant_id !== exp_port) begin
        n_err++; $display("FAIL contention_order[%0d] got %h/%b want %h/%b", n, bus.uart_tx_data, bus.grant_id, exp_data, exp_port);
      end
      n_cmp++; if (bus.req0_ready !== !exp_port || bus.req1_ready !== exp_port) begin
        n_err++; $display("FAIL contention_ready[%0d] got %b%b want %b%b", n, bus.req0_ready, bus.req1_ready, !exp_port, exp_port);
      end
      last_grant = exp_port;
      last_byte  = exp_data;
      if (n == 5) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      finish_frame(2 + n % 3, en_seen);
      n_cmp++; if (en_seen != 0) begin n_err++; $display("FAIL contention_en_while_busy[%0d] got %0d want 0", n, en_seen); end
    end
    settle_idle(ok);
  endtask

  task automatic test_ext_busy();
    int cyc, en_seen, en_cnt;
    bit ok;
    step();
    bus.uart_tx_busy = 1'b1;
    bus.req1_valid   = 1'b1;
    bus.req1_data    = 8'h5C;
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.uart_tx_en !== 1'b0 || bus.arb_idle !== 1'b1) en_cnt++;
    end
    n_cmp++; if (en_cnt != 0) begin n_err++; $display("FAIL ext_busy_hold got %0d bad cycles want 0", en_cnt); end
    step();
    bus.uart_tx_busy = 1'b0;
    wait_launch(cyc, ok);
    n_cmp++; if (!ok || cyc != LaunchLat) begin n_err++; $display("FAIL ext_busy_latency got %0d want %0d", cyc, LaunchLat); end
    n_cmp++; if (bus.uart_tx_data !== 8'h5C || bus.req1_ready !== 1'b1 || bus.grant_id !== 1'b1) begin
      n_err++; $display("FAIL ext_busy_launch got %h/%b/%b want 5c/1/1", bus.uart_tx_data, bus.req1_ready, bus.grant_id);
    end
    bus.req1_valid = 1'b0;
    last_grant = 1'b1;
    last_byte  = 8'h5C;
    finish_frame(2, en_seen);
    settle_idle(ok);
  endtask

  task automatic test_reset_mid();
    int cyc, en_seen;
    bit ok;
    // Launch from port 0 so a DUT that ignored reset would favour port 1 next.
    step();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    wait_launch(cyc, ok);
    bus.req0_valid = 1'b0;
    step();
    bus.uart_tx_busy = 1'b1;
    step();
    step();  // now in WAIT_DONE with busy high
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.uart_tx_en !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_strobes got %b%b%b want 000", bus.uart_tx_en, bus.req0_ready, bus.req1_ready);
    end
    n_cmp++; if (bus.uart_tx_data !== 8'h00 || bus.grant_id !== 1'b1 || bus.arb_idle !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_state got %h/%b/%b want 00/1/1", bus.uart_tx_data, bus.grant_id, bus.arb_idle);
    end
    bus.uart_tx_busy = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h33;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h44;
    step();
    rst_n = 1'b1;
    wait_launch(cyc, ok);
    n_cmp++; if (!ok || bus.uart_tx_data !== 8'h33 || bus.grant_id !== 1'b0 || cyc != LaunchLat) begin
      n_err++; $display("FAIL reset_mid_first_winner got %h/%b lat %0d want 33/0 lat %0d", bus.uart_tx_data, bus.grant_id, cyc, LaunchLat);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    last_grant = 1'b0;
    last_byte  = 8'h33;
    finish_frame(2, en_seen);
    settle_idle(ok);
  endtask

  task automatic test_gap();
    int cyc, en_seen, busy_idle_cnt;
    bit ok;
    step();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h9E;
    wait_launch(cyc, ok);
    bus.req1_valid = 1'b0;
    last_grant = 1'b1;
    last_byte  = 8'h9E;
    finish_frame(2, en_seen);
    @(posedge clk);  // arbiter samples busy low here
    busy_idle_cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.arb_idle === 1'b1) ok = 1'b1;
      else busy_idle_cnt++;
    end
    n_cmp++; if (!ok || busy_idle_cnt != GapExtra) begin
      n_err++; $display("FAIL gap_length got %0d want %0d", busy_idle_cnt, GapExtra);
    end
  endtask

  task automatic test_random();
    int cyc, en_seen, pre;
    bit ok, exp_port;
    bit [1:0] mask;
    byte unsigned d0, d1, exp_data;
    for (int n = 0; n < 24; n++) begin
      mask = 2'($urandom_range(1, 3));
      d0   = 8'($urandom);
      d1   = 8'($urandom);
      pre  = $urandom_range(0, 2);
      exp_port = (mask == 2'b11) ? ~last_grant : mask[1];
      exp_data = exp_port ? d1 : d0;
      step();
      n_cmp++; if (bus.uart_tx_data !== last_byte) begin
        n_err++; $display("FAIL rand_hold[%0d] got %h want %h", n, bus.uart_tx_data, last_byte);
      end
      bus.req0_valid = mask[0]; bus.req0_data = d0;
      bus.req1_valid = mask[1]; bus.req1_data = d1;
      bus.uart_tx_busy = (pre > 0);
      if (pre > 0) begin
        repeat (pre) step();
        bus.uart_tx_busy = 1'b0;
      end
      wait_launch(cyc, ok);
      n_cmp++; if (!ok || cyc != LaunchLat) begin n_err++; $display("FAIL rand_latency[%0d] got %0d want %0d", n, cyc, LaunchLat); end
      n_cmp++; if (bus.uart_tx_data !== exp_data || bus.grant_id !== exp_port) begin
        n_err++; $display("FAIL rand_winner[%0d] got %h/%b want %h/%b", n, bus.uart_tx_data, bus.grant_id, exp_data, exp_port);
      end
      n_cmp++; if (bus.req0_ready !== !exp_port || bus.req1_ready !== exp_port) begin
        n_err++; $display("FAIL rand_ready[%0d] got %b%b want %b%b", n, bus.req0_ready, bus.req1_ready, !exp_port, exp_port);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      last_grant = exp_port;
      last_byte  = exp_data;
      finish_frame($urandom_range(1, 4), en_seen);
      settle_idle(ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_return_idle[%0d] got 0 want 1", n); end
    end
  endtask

  initial begin
    bus.req0_valid   = 1'b0;
    bus.req0_data    = 8'h00;
    bus.req1_valid   = 1'b0;
    bus.req1_data    = 8'h00;
    bus.uart_tx_busy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_ext_busy();
    test_reset_mid();
    test_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
